// File: rtl/transpose_pingpong_mem.sv
// Ping-pong N x N block store between the IDCT row and column passes.
// Samples arrive row-major, one per cycle. Each completed block is emitted either
// transposed (column-major) or in its original order, chosen per block by `mode`.
// One bank fills while the other drains, so both sides can sustain one sample per cycle.
// Optional feature: define TPM_BLKCNT_EN to enable the drained-block counter on blk_count;
// without it blk_count is tied to zero and the counter logic is absent.

module transpose_pingpong_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_write,
  input  logic              enable,
  output logic              wr_ready,
  input  logic              mode,
  output logic [DATA_W-1:0] data_read,
  output logic              readenable,
  input  logic              rd_ready,
  output logic              tmpmode,
  output logic              rd_last,
  output logic [15:0]       blk_count
);

  // Derived sizes; N is a power of two, so N*N-1 is all ones and counters wrap by themselves.
  localparam int unsigned AW    = $clog2(N * N);
  localparam int unsigned LN    = $clog2(N);
  localparam int unsigned Depth = 2 * N * N;
  localparam logic [AW-1:0] LastIdx = {AW{1'b1}};

  typedef enum logic [1:0] {
    StEmpty,
    StFilling,
    StFull,
    StDraining
  } bank_st_e;

  // Per-bank lifecycle state
  bank_st_e bank_q [2];
  bank_st_e bank_d [2];

  // Write/read pointers: bank select plus element counter
  logic          wsel_q;
  logic          rsel_q;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] rcnt_q;

  // Per-bank mode tag captured with element 0
  logic          tag_q [2];

  // Both banks share one array; the bank select is the address MSB
  logic [DATA_W-1:0] mem [Depth];

  // Registered output stage
  logic              readenable_q;
  logic [DATA_W-1:0] data_read_q;
  logic              tmpmode_q;
  logic              rd_last_q;

  // Handshake and control strobes
  logic          wr_fire;
  logic          wr_done;
  logic          out_free;
  logic          rd_issue;
  logic          rd_done;
  logic [AW-1:0] rd_addr;

  // Bank state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0] <= StEmpty;
      bank_q[1] <= StEmpty;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // Bank next-state: the write side only ever touches EMPTY/FILLING banks and the read side
  // only FULL/DRAINING banks, so the two updates never target the same bank in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (wr_fire && (wsel_q == b[0])) begin
        bank_d[b] = wr_done ? StFull : StFilling;
      end
      if (rd_issue && (rsel_q == b[0])) begin
        bank_d[b] = rd_done ? StEmpty : StDraining;
      end
    end
  end

  // Handshake decode from registered bank state; no same-cycle bypass of a freed bank
  always_comb begin
    wr_ready = 1'b0;
    wr_fire  = 1'b0;
    wr_done  = 1'b0;
    out_free = 1'b0;
    rd_issue = 1'b0;
    rd_done  = 1'b0;

    // Held low while reset is asserted, even though the banks already read EMPTY
    wr_ready = rst_n && ((bank_q[wsel_q] == StEmpty) || (bank_q[wsel_q] == StFilling));
    wr_fire  = enable && wr_ready;
    wr_done  = wr_fire && (wcnt_q == LastIdx);

    // A new read may issue when the output register is empty or being consumed this cycle
    out_free = !readenable_q || rd_ready;
    rd_issue = rst_n && out_free &&
               ((bank_q[rsel_q] == StFull) || (bank_q[rsel_q] == StDraining));
    rd_done  = rd_issue && (rcnt_q == LastIdx);
  end

  // Read address: transpose swaps the row/column halves of the element index,
  // giving (k % N) * N + k / N.
  always_comb begin
    rd_addr = rcnt_q;
    if (tag_q[rsel_q]) begin
      rd_addr = {rcnt_q[LN-1:0], rcnt_q[AW-1:LN]};
    end
  end

  // Pointer, counter and mode-tag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      tag_q[0] <= 1'b0;
      tag_q[1] <= 1'b0;
    end else begin
      if (wr_fire) begin
        wcnt_q <= wcnt_q + 1'b1;
        // Mode changes after element 0 are ignored until the next block starts
        if (wcnt_q == '0) begin
          tag_q[wsel_q] <= mode;
        end
        if (wr_done) begin
          wsel_q <= ~wsel_q;
        end
      end
      if (rd_issue) begin
        rcnt_q <= rcnt_q + 1'b1;
        if (rd_done) begin
          rsel_q <= ~rsel_q;
        end
      end
    end
  end

  // Sample storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wsel_q, wcnt_q}] <= data_write;
    end
  end

  // Registered output stage: loads on issue, holds under back-pressure, empties when consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readenable_q <= 1'b0;
      data_read_q  <= '0;
      tmpmode_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else if (rd_issue) begin
      readenable_q <= 1'b1;
      data_read_q  <= mem[{rsel_q, rd_addr}];
      tmpmode_q    <= tag_q[rsel_q];
      rd_last_q    <= rd_done;
    end else if (out_free) begin
      readenable_q <= 1'b0;
      rd_last_q    <= 1'b0;
    end
  end

  assign readenable = readenable_q;
  assign data_read  = data_read_q;
  assign tmpmode    = tmpmode_q;
  assign rd_last    = rd_last_q;

`ifdef TPM_BLKCNT_EN
  logic [15:0] blk_count_q;

  // Count blocks whose final sample has been handed to the consumer; wraps at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_count_q <= '0;
    end else if (readenable_q && rd_ready && rd_last_q) begin
      blk_count_q <= blk_count_q + 16'd1;
    end
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_transpose_pingpong_mem.sv
// Directed bench for transpose_pingpong_mem (N=8, DATA_W=16, 40 ns clock).
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.

module tb_transpose_pingpong_mem;

  localparam int NN = 64;

`ifdef TPM_BLKCNT_EN
  localparam int BlkEn = 1;
`else
  localparam int BlkEn = 0;
`endif

  typedef logic [17:0] smp_t;  // {tmpmode, rd_last, data_read}

  typedef struct {
    int          pos;
    logic [15:0] data;
    logic        tm;
    logic        last;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_write;
  logic        enable;
  logic        wr_ready;
  logic        mode;
  logic [15:0] data_read;
  logic        readenable;
  logic        rd_ready;
  logic        tmpmode;
  logic        rd_last;
  logic [15:0] blk_count;

  logic rdy_cmd;
  logic rand_rdy;
  logic rnd_bit;

  int   n_vec;
  int   n_bad;
  int   cyc;
  int   acc_cnt;
  int   wr_stall_cnt;
  logic w_done;

  smp_t out_q[$];
  smp_t exp_q[$];
  int   out_cyc_q[$];

  vec_t tv1[8];
  vec_t tv2[8];

  logic prev_stall;
  smp_t prev_out;

  transpose_pingpong_mem #(
    .DATA_W(16),
    .N     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_write(data_write),
    .enable    (enable),
    .wr_ready  (wr_ready),
    .mode      (mode),
    .data_read (data_read),
    .readenable(readenable),
    .rd_ready  (rd_ready),
    .tmpmode   (tmpmode),
    .rd_last   (rd_last),
    .blk_count (blk_count)
  );

  assign rd_ready = rand_rdy ? rnd_bit : rdy_cmd;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 1) == 1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Handshake monitor plus hold-under-stall check
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("stall_hold", {13'd0, readenable, tmpmode, rd_last, data_read}, {13'd0, 1'b1, prev_out});
    end
    prev_stall = rst_n && readenable && !rd_ready;
    prev_out   = {tmpmode, rd_last, data_read};
    if (rst_n && enable && wr_ready) acc_cnt++;
    if (rst_n && enable && !wr_ready) wr_stall_cnt++;
    if (rst_n && readenable && rd_ready) begin
      out_q.push_back({tmpmode, rd_last, data_read});
      out_cyc_q.push_back(cyc);
    end
  end

  // Expected stream for one block: transposed index is (k % 8) * 8 + k / 8
  function automatic void add_block(input int base, input logic m);
    for (int k = 0; k < NN; k++) begin
      int d;
      d = m ? base + (k % 8) * 8 + k / 8 : base + k;
      exp_q.push_back({m, (k == NN - 1), 16'(d)});
    end
  endfunction

  // Drive cnt samples base, base+1, ...; mode is m on element 0 and inverted afterwards
  task automatic write_block(input int base, input logic m, input int cnt);
    int i;
    int guard;
    i     = 0;
    guard = 0;
    while (i < cnt) begin
      data_write = 16'(base + i);
      mode       = (i == 0) ? m : ~m;
      enable     = 1'b1;
      @(negedge clk);
      if (wr_ready) i++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3000) begin
        n_vec++;
        n_bad++;
        $display("FAIL write_timeout: got %0d accepted expected %0d", i, cnt);
        break;
      end
    end
    enable = 1'b0;
  endtask

  task automatic wait_out(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({name, "_avail"}, (out_q.size() >= n), 1);
  endtask

  task automatic cmp_stream(input string name);
    int   bad;
    int   idx;
    smp_t got;
    chk({name, "_count"}, out_q.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() / NN; b++) begin
      bad = -1;
      for (int k = 0; k < NN; k++) begin
        idx = b * NN + k;
        if (bad < 0 && (idx >= out_q.size() || out_q[idx] !== exp_q[idx])) bad = idx;
      end
      n_vec++;
      if (bad >= 0) begin
        got = (bad < out_q.size()) ? out_q[bad] : '1;
        n_bad++;
        $display("FAIL %s_blk%0d: sample %0d got %h expected %h", name, b, bad, got, exp_q[bad]);
      end
    end
  endtask

  task automatic cmp_table(input string name, input vec_t tv[8]);
    smp_t got;
    for (int i = 0; i < 8; i++) begin
      got = (tv[i].pos < out_q.size()) ? out_q[tv[i].pos] : '1;
      chk($sformatf("%s_pos%0d", name, tv[i].pos), {14'd0, got},
          {14'd0, tv[i].tm, tv[i].last, tv[i].data});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed vectors: block 0..63, transposed
    tv1[0] = '{0,  16'd0,  1'b1, 1'b0};
    tv1[1] = '{1,  16'd8,  1'b1, 1'b0};
    tv1[2] = '{7,  16'd56, 1'b1, 1'b0};
    tv1[3] = '{8,  16'd1,  1'b1, 1'b0};
    tv1[4] = '{9,  16'd9,  1'b1, 1'b0};
    tv1[5] = '{30, 16'd51, 1'b1, 1'b0};
    tv1[6] = '{62, 16'd55, 1'b1, 1'b0};
    tv1[7] = '{63, 16'd63, 1'b1, 1'b1};
    // A = 0..63 pass-through, then B = 100..163 transposed
    tv2[0] = '{0,   16'd0,   1'b0, 1'b0};
    tv2[1] = '{5,   16'd5,   1'b0, 1'b0};
    tv2[2] = '{63,  16'd63,  1'b0, 1'b1};
    tv2[3] = '{64,  16'd100, 1'b1, 1'b0};
    tv2[4] = '{65,  16'd108, 1'b1, 1'b0};
    tv2[5] = '{71,  16'd156, 1'b1, 1'b0};
    tv2[6] = '{72,  16'd101, 1'b1, 1'b0};
    tv2[7] = '{127, 16'd163, 1'b1, 1'b1};

    n_vec        = 0;
    n_bad        = 0;
    cyc          = 0;
    acc_cnt      = 0;
    wr_stall_cnt = 0;
    w_done       = 1'b0;
    prev_stall   = 1'b0;
    prev_out     = '0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    mode         = 1'b0;
    data_write   = '0;
    rdy_cmd      = 1'b1;
    rand_rdy     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_readenable", readenable, 0);
    chk("rst_data_read", data_read, 0);
    chk("rst_tmpmode", tmpmode, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_blk_count", blk_count, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1);

    // 1: single transposed block, latency
    write_block(0, 1'b1, NN);
    chk("lat_edge_t1", readenable, 0);
    @(posedge clk);
    #1;
    chk("lat_edge_t2_valid", readenable, 1);
    chk("lat_edge_t2_data", data_read, 0);
    add_block(0, 1'b1);
    wait_out("t1", NN, 200);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_drop_valid", readenable, 0);
    cmp_table("t1", tv1);
    cmp_stream("t1");

    // 2: back-to-back blocks, no write stall, no read bubbles
    out_q.delete();
    exp_q.delete();
    out_cyc_q.delete();
    wr_stall_cnt = 0;
    write_block(0, 1'b0, NN);
    write_block(100, 1'b1, NN);
    chk("t2_wr_stalls", wr_stall_cnt, 0);
    add_block(0, 1'b0);
    add_block(100, 1'b1);
    wait_out("t2", 2 * NN, 200);
    chk("t2_no_bubbles", (out_cyc_q.size() == 2 * NN) ? out_cyc_q[2 * NN - 1] - out_cyc_q[0] : -1,
        2 * NN - 1);
    cmp_table("t2", tv2);
    cmp_stream("t2");

    // 3: consumer stalled, both banks fill, third block waits for a drained bank
    out_q.delete();
    exp_q.delete();
    rdy_cmd = 1'b0;
    begin
      int a0;
      int c;
      a0 = acc_cnt;
      fork
        begin
          write_block(200, 1'b0, NN);
          write_block(300, 1'b1, NN);
          write_block(400, 1'b0, NN);
          w_done = 1'b1;
        end
      join_none
      c = 0;
      while ((acc_cnt - a0) < 2 * NN && c < 600) begin
        @(posedge clk);
        #1;
        c++;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("t3_accepts_when_full", acc_cnt - a0, 2 * NN);
      chk("t3_wr_ready_low", wr_ready, 0);
      chk("t3_held_valid", readenable, 1);
      chk("t3_held_data", data_read, 200);
      rdy_cmd = 1'b1;
      c = 0;
      while (!w_done && c < 1000) begin
        @(posedge clk);
        #1;
        c++;
      end
      chk("t3_writer_done", w_done, 1);
    end
    add_block(200, 1'b0);
    add_block(300, 1'b1);
    add_block(400, 1'b0);
    wait_out("t3", 3 * NN, 400);
    cmp_stream("t3");

    // 4: random consumer stalls
    out_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    write_block(500, 1'b1, NN);
    write_block(600, 1'b0, NN);
    add_block(500, 1'b1);
    add_block(600, 1'b0);
    wait_out("t4", 2 * NN, 1500);
    rand_rdy = 1'b0;
    cmp_stream("t4");
    repeat (3) @(posedge clk);
    #1;
    chk("blk_count_before_rst", blk_count, BlkEn ? 8 : 0);

    // 5: reset after a partial block
    out_q.delete();
    exp_q.delete();
    write_block(800, 1'b1, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_wr_ready", wr_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_wr_ready_after", wr_ready, 1);
    chk("t5_blk_count_rst", blk_count, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_output", out_q.size(), 0);
    chk("t5_readenable", readenable, 0);
    write_block(900, 1'b1, NN);
    add_block(900, 1'b1);
    wait_out("t5", NN, 200);
    cmp_stream("t5");

    // 6: four more blocks, five drained since reset
    out_q.delete();
    exp_q.delete();
    write_block(1000, 1'b0, NN);
    write_block(1100, 1'b1, NN);
    write_block(1200, 1'b0, NN);
    write_block(1300, 1'b1, NN);
    add_block(1000, 1'b0);
    add_block(1100, 1'b1);
    add_block(1200, 1'b0);
    add_block(1300, 1'b1);
    wait_out("t6", 4 * NN, 400);
    cmp_stream("t6");
    repeat (3) @(posedge clk);
    #1;
    chk("t6_blk_count", blk_count, BlkEn ? 5 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
